vec_store_unit: RTL and testbench

Vector store unit that drains one V-lane vector result (as produced by the vector ALU) into word-addressed data memory, one lane per cycle. It sits between the execute/writeback stage and the data-memory write port. It captures the vector, base address, stride and lane mask on a start pulse, then serializes the lanes with a ready-based stall handshake. It signals completion with a one-cycle done pulse.

---
 rtl/vec_pkg.sv | 12 +
 rtl/vec_addr_gen.sv | 55 +++++
 rtl/vec_store_unit.sv | 98 +++++++++
 tb/tb_vec_store_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared defaults and state encoding for the vector store unit
package vec_pkg;
    localparam int N_DEF  = 16;
    localparam int V_DEF  = 16;
    localparam int AW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } vst_state_t;
endpackage

// File: rtl/vec_addr_gen.sv
// rtl/vec_addr_gen.sv - lane index counter and strided address accumulator
module vec_addr_gen
    import vec_pkg::*;
#(
    parameter int V    = V_DEF,
    parameter int AW   = AW_DEF,
    parameter int IDXW = (V > 1) ? $clog2(V) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            adv_i,
    input  logic [AW-1:0]   base_i,
    input  logic [AW-1:0]   stride_i,
    output logic [IDXW-1:0] idx_o,
    output logic [AW-1:0]   addr_o,
    output logic            last_o
);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(V - 1);

    logic [IDXW-1:0] idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   stride_q, stride_d;

    always_comb begin
        idx_d    = idx_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load_i) begin
            idx_d    = '0;
            addr_d   = base_i;
            stride_d = stride_i;
        end else if (adv_i) begin
            idx_d  = idx_q + IDXW'(1);
            // Address wrap past 2^AW is silent by design.
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = addr_q;
    assign last_o = (idx_q == LAST_IDX);
endmodule

// File: rtl/vec_store_unit.sv
// rtl/vec_store_unit.sv - serializes one captured vector into memory, one lane per cycle
module vec_store_unit
    import vec_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int V  = V_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [V-1:0][N-1:0] vec_in,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW-1:0]       stride,
    input  logic [V-1:0]        lane_mask,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [N-1:0]        mem_wdata,
    output logic                busy,
    output logic                done
);
    localparam int IDXW = (V > 1) ? $clog2(V) : 1;

    vst_state_t          state_q, state_d;
    logic [V-1:0][N-1:0] vec_q;
    logic [V-1:0]        mask_q;
    logic                load, adv, last;
    logic [IDXW-1:0]     idx;
    logic [AW-1:0]       cur_addr;
    logic                lane_we;
    logic [N-1:0]        lane_data;

    vec_addr_gen #(.V(V), .AW(AW), .IDXW(IDXW)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .adv_i    (adv),
        .base_i   (base_addr),
        .stride_i (stride),
        .idx_o    (idx),
        .addr_o   (cur_addr),
        .last_o   (last)
    );

    assign lane_we   = mask_q[idx];
    assign lane_data = vec_q[idx];

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        adv       = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = lane_we;
                mem_addr  = cur_addr;
                mem_wdata = lane_data;
                // Skipped lanes never wait for the memory.
                if (mem_ready || !lane_we) begin
                    adv = 1'b1;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                vec_q  <= vec_in;
                mask_q <= lane_mask;
            end
        end
    end
endmodule

// File: tb/tb_vec_store_unit.sv
// tb/tb_vec_store_unit.sv - directed table-driven bench for vec_store_unit
module tb_vec_store_unit;
    localparam int N  = 16;
    localparam int V  = 16;
    localparam int AW = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [V-1:0][N-1:0] vec_in;
    logic [AW-1:0]       base_addr;
    logic [AW-1:0]       stride;
    logic [V-1:0]        lane_mask;
    logic                mem_ready;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [N-1:0]        mem_wdata;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    vec_store_unit #(.N(N), .V(V), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_in    (vec_in),
        .base_addr (base_addr),
        .stride    (stride),
        .lane_mask (lane_mask),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [15:0] base;
        logic [15:0] stride;
        logic [15:0] mask;
        logic [15:0] dbase;
        int          stall_lane;
        int          stall_n;
        logic        hold_start;
        int          exp_done;
        int          exp_writes;
        logic [15:0] exp_last;
    } case_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge with the DUT idle; leaves it idle at a falling edge.
    task automatic run_case(input case_t tc);
        int          lane, stalls_left, writes, done_cyc;
        logic [15:0] last_a, ea;
        logic        rdy;
        for (int k = 0; k < V; k++) vec_in[k] = tc.dbase + 16'(k);
        base_addr = tc.base;
        stride    = tc.stride;
        lane_mask = tc.mask;
        start     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (!tc.hold_start) start = 1'b0;
        for (int k = 0; k < V; k++) vec_in[k] = 16'hDEAD;
        base_addr = 16'h5555;
        stride    = 16'h0007;
        lane_mask = ~tc.mask;
        lane = 0; stalls_left = tc.stall_n; writes = 0; done_cyc = 0; last_a = '0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            if (lane < V) begin
                ea = 16'(tc.base + 16'(tc.stride * 16'(lane)));
                chk("lane_we", mem_we, tc.mask[lane]);
                chk("lane_addr", mem_addr, ea);
                chk("lane_data", mem_wdata, tc.dbase + 16'(lane));
                chk("lane_busy", busy, 1);
                chk("lane_done", done, 0);
                rdy = !(lane == tc.stall_lane && stalls_left > 0);
                if (!rdy) stalls_left--;
                mem_ready = rdy;
                if (rdy || !tc.mask[lane]) begin
                    if (tc.mask[lane]) begin
                        writes++;
                        last_a = ea;
                    end
                    lane++;
                end
            end else begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("done_we", mem_we, 0);
                done_cyc = c;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("done_cycle", done_cyc, tc.exp_done);
        chk("write_count", writes, tc.exp_writes);
        if (tc.exp_writes > 0) chk("last_addr", last_a, tc.exp_last);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_data", mem_wdata, 0);
        start     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("after_busy", busy, 0);
            chk("after_done", done, 0);
        end
    endtask

    case_t cases[6];

    initial begin
        cases[0] = '{16'h0100, 16'h0001, 16'hFFFF, 16'h1000, -1, 0, 1'b1, 17, 16, 16'h010F};
        cases[1] = '{16'h0200, 16'h0004, 16'h00F0, 16'h2000, -1, 0, 1'b0, 17,  4, 16'h021C};
        cases[2] = '{16'h0300, 16'h0001, 16'hFFFF, 16'h3000,  2, 3, 1'b0, 20, 16, 16'h030F};
        cases[3] = '{16'hFFFE, 16'h0001, 16'hFFFF, 16'h4000, -1, 0, 1'b0, 17, 16, 16'h000D};
        cases[4] = '{16'h0500, 16'h0002, 16'h0000, 16'h5000, -1, 0, 1'b0, 17,  0, 16'h0000};
        cases[5] = '{16'h0600, 16'h0001, 16'hFFFB, 16'h6000,  2, 3, 1'b0, 17, 15, 16'h060F};

        rst = 1'b1; start = 1'b0; vec_in = '0; base_addr = '0;
        stride = '0; lane_mask = '0; mem_ready = 1'b0;
        #12;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_case(cases[i]);

        // Reset while lane 5 is on the bus abandons the vector with no done pulse.
        for (int k = 0; k < V; k++) vec_in[k] = 16'h7000 + 16'(k);
        base_addr = 16'h0400; stride = 16'h0001; lane_mask = 16'hFFFF;
        start = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_addr", mem_addr, 16'h0405);
        chk("pre_rst_data", mem_wdata, 16'h7005);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_data", mem_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            @(posedge clk);
            @(negedge clk);
        end
        run_case(cases[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
